// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl
// Run/step/halt sequencer for a 5-stage MIPS pipeline. It drives the
// pipeline-wide register enable and the PC/fetch enable. Software-style
// commands (RUN, STEP N, HALT, CLEAR) control execution. A HALT opcode seen
// in IF/ID stops fetch, drains the in-flight instructions and then freezes
// the pipeline. The block counts every cycle in which the pipeline advanced.
//
// Optional build macro: PIPELINE_RUN_CTRL_BREAKPOINT_EN adds a PC breakpoint
// (bp_valid, bp_pc, pc_IF in; bp_hit out).
//
// Ports:
//   clk               pipeline clock
//   reset             asynchronous, active-low
//   cmd_valid/ready   command handshake, taken when both are high at posedge
//   cmd_op            00 RUN, 01 STEP, 10 HALT, 11 CLEAR
//   cmd_count         cycle count for STEP
//   instruction_IF_ID IF/ID instruction register contents
//   pipe_en           enable for all pipeline registers
//   fetch_en          enable for PC update/fetch
//   busy              running, stepping or draining
//   halted            frozen after a drained HALT opcode
//   done              one-cycle completion pulse
//   cycle_count       saturating count of cycles with pipe_en=1
//   bp_valid/bp_pc    breakpoint arm and address (optional)
//   pc_IF             PC of the instruction being fetched (optional)
//   bp_hit            sticky breakpoint indication (optional)
module pipeline_run_ctrl #(
  parameter int unsigned CYCLE_W      = 32,
  parameter int unsigned STEP_W       = 16,
  parameter logic [5:0]  HALT_OPCODE  = 6'b111111,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [STEP_W-1:0]  cmd_count,
  input  logic [31:0]        instruction_IF_ID,
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
  input  logic               bp_valid,
  input  logic [31:0]        bp_pc,
  input  logic [31:0]        pc_IF,
  output logic               bp_hit,
`endif
  output logic               pipe_en,
  output logic               fetch_en,
  output logic               busy,
  output logic               halted,
  output logic               done,
  output logic [CYCLE_W-1:0] cycle_count
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_HALTED
  } state_t;

  typedef enum logic [1:0] {
    OP_RUN   = 2'b00,
    OP_STEP  = 2'b01,
    OP_HALT  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  state_t              state, state_n;
  logic [STEP_W-1:0]   step_cnt, step_n;
  logic [DRAIN_W-1:0]  drain_cnt, drain_n;
  logic                done_n;
  logic                clear_cnt;
  logic                cmd_acc;
  logic                running;
  logic                halt_det;
  op_t                 op;
  logic                unused_instr_bits;

  // Only the opcode field matters here.
  assign unused_instr_bits = ^instruction_IF_ID[25:0];

  assign cmd_acc  = cmd_valid && cmd_ready;
  assign op       = op_t'(cmd_op);
  assign running  = ((state == S_RUN) || (state == S_STEP)) && pipe_en;
  assign halt_det = running && (instruction_IF_ID[31:26] == HALT_OPCODE);

`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
  logic bp_det;
  logic bp_n;
  assign bp_det = running && fetch_en && bp_valid && (pc_IF == bp_pc);
`endif

  always_comb begin
    state_n   = state;
    step_n    = step_cnt;
    drain_n   = drain_cnt;
    done_n    = 1'b0;
    clear_cnt = 1'b0;
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
    bp_n      = cmd_acc ? 1'b0 : bp_hit;
`endif

    // Halt-opcode detection outranks step expiry, breakpoints and any
    // command taken in the same cycle; such a command is consumed unused.
    if (halt_det) begin
      step_n = '0;
      if (DRAIN_CYCLES == 0) begin
        state_n = S_HALTED;
        done_n  = 1'b1;
      end else begin
        state_n = S_DRAIN;
        drain_n = DRAIN_W'(DRAIN_CYCLES);
      end
    end
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
    else if (bp_det) begin
      state_n = S_IDLE;
      step_n  = '0;
      done_n  = 1'b1;
      bp_n    = 1'b1;
    end
`endif
    else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_acc) begin
            unique case (op)
              OP_RUN:  state_n = S_RUN;
              OP_STEP: begin
                if (cmd_count != '0) begin
                  state_n = S_STEP;
                  step_n  = cmd_count;
                end else begin
                  done_n = 1'b1;
                end
              end
              OP_HALT:  done_n    = 1'b1;
              OP_CLEAR: clear_cnt = 1'b1;
            endcase
          end
        end
        S_RUN: begin
          if (cmd_acc) begin
            unique case (op)
              OP_HALT: begin
                state_n = S_IDLE;
                done_n  = 1'b1;
              end
              OP_CLEAR: clear_cnt = 1'b1;
              default: ;
            endcase
          end
        end
        S_STEP: begin
          if (step_cnt <= STEP_W'(1)) begin
            state_n = S_IDLE;
            step_n  = '0;
            done_n  = 1'b1;
          end else begin
            step_n = step_cnt - STEP_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt <= DRAIN_W'(1)) begin
            state_n = S_HALTED;
            drain_n = '0;
            done_n  = 1'b1;
          end else begin
            drain_n = drain_cnt - DRAIN_W'(1);
          end
        end
        S_HALTED: begin
          if (cmd_acc && (op == OP_CLEAR)) begin
            state_n   = S_IDLE;
            clear_cnt = 1'b1;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered and line
  // up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      step_cnt    <= '0;
      drain_cnt   <= '0;
      pipe_en     <= 1'b0;
      fetch_en    <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      done        <= 1'b0;
      cmd_ready   <= 1'b1;  // reset lands in IDLE, which accepts commands
      cycle_count <= '0;
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
      bp_hit      <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      step_cnt  <= step_n;
      drain_cnt <= drain_n;
      pipe_en   <= (state_n == S_RUN) || (state_n == S_STEP) || (state_n == S_DRAIN);
      fetch_en  <= (state_n == S_RUN) || (state_n == S_STEP);
      busy      <= (state_n == S_RUN) || (state_n == S_STEP) || (state_n == S_DRAIN);
      halted    <= (state_n == S_HALTED);
      done      <= done_n;
      cmd_ready <= (state_n == S_IDLE) || (state_n == S_RUN) || (state_n == S_HALTED);
      // A CLEAR taken while running replaces that cycle's increment.
      if (clear_cnt) begin
        cycle_count <= '0;
      end else if (pipe_en && (cycle_count != '1)) begin
        cycle_count <= cycle_count + 1'b1;
      end
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
      bp_hit    <= bp_n;
`endif
    end
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl. A second instance with a 4-bit cycle
// counter shares all inputs to exercise counter saturation.
module tb_pipeline_run_ctrl;

  localparam int DRAIN = 4;
  localparam logic [31:0] HALT_I = 32'hFC00_0000;
  localparam logic [1:0] C_RUN = 2'b00, C_STEP = 2'b01, C_HALT = 2'b10, C_CLEAR = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_count = 16'd0;
  logic [31:0] instr = 32'd0;

  logic        cmd_ready, pipe_en, fetch_en, busy, halted, done;
  logic [31:0] cycle_count;
  logic        r4, pe4, fe4, busy4, halted4, done4;
  logic [3:0]  cc4;

`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
  logic        bp_valid = 1'b0;
  logic [31:0] bp_pc = 32'd0;
  logic [31:0] pc_if = 32'd0;
  logic        bp_hit, bp_hit4;
`endif

  always #5 clk = ~clk;

  pipeline_run_ctrl u_dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .instruction_IF_ID(instr),
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
    .bp_valid(bp_valid), .bp_pc(bp_pc), .pc_IF(pc_if), .bp_hit(bp_hit),
`endif
    .pipe_en(pipe_en), .fetch_en(fetch_en), .busy(busy), .halted(halted),
    .done(done), .cycle_count(cycle_count)
  );

  pipeline_run_ctrl #(.CYCLE_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(r4),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .instruction_IF_ID(instr),
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
    .bp_valid(bp_valid), .bp_pc(bp_pc), .pc_IF(pc_if), .bp_hit(bp_hit4),
`endif
    .pipe_en(pe4), .fetch_en(fe4), .busy(busy4), .halted(halted4),
    .done(done4), .cycle_count(cc4)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: act_left is the number of enabled cycles still to come
  // (-1 = free running, 0 = pipeline stopped).
  int     act_left = 0;
  bit     draining = 0;
  bit     halted_m = 0;
  bit     done_m = 0;
  bit     bp_m = 0;
  longint cnt = 0;
  longint cnt4 = 0;

  always @(posedge clk or negedge reset) begin : model
    bit pe, runmode, acc;
    if (!reset) begin
      act_left = 0; draining = 0; halted_m = 0; done_m = 0; bp_m = 0;
      cnt = 0; cnt4 = 0;
    end else begin
      pe      = (act_left != 0);
      runmode = pe && !draining;
      acc     = cmd_valid && (act_left <= 0);
      done_m  = 0;
      if (pe) begin
        cnt  = (cnt == 64'hFFFF_FFFF) ? cnt : cnt + 1;
        cnt4 = (cnt4 == 15) ? 15 : cnt4 + 1;
      end
      if (acc) bp_m = 0;
      if (runmode && instr[31:26] == 6'b111111) begin
        draining = 1;
        act_left = DRAIN;
      end
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
      else if (runmode && bp_valid && pc_if == bp_pc) begin
        act_left = 0; done_m = 1; bp_m = 1;
      end
`endif
      else if (act_left > 0) begin
        act_left--;
        if (act_left == 0) begin
          done_m = 1;
          if (draining) begin draining = 0; halted_m = 1; end
        end
      end else if (acc) begin
        case (cmd_op)
          C_RUN:   if (!halted_m) act_left = -1;
          C_STEP:  if (!halted_m && act_left == 0) begin
                     if (cmd_count != 0) act_left = int'(cmd_count);
                     else done_m = 1;
                   end
          C_HALT:  if (!halted_m) begin act_left = 0; done_m = 1; end
          default: begin cnt = 0; cnt4 = 0; halted_m = 0; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("pipe_en", pipe_en, act_left != 0);
    chk("fetch_en", fetch_en, (act_left != 0) && !draining);
    chk("busy", busy, act_left != 0);
    chk("halted", halted, halted_m);
    chk("done", done, done_m);
    chk("cmd_ready", cmd_ready, act_left <= 0);
    chk("cycle_count", cycle_count, cnt);
    chk("pipe_en4", pe4, act_left != 0);
    chk("fetch_en4", fe4, (act_left != 0) && !draining);
    chk("busy4", busy4, act_left != 0);
    chk("halted4", halted4, halted_m);
    chk("done4", done4, done_m);
    chk("cmd_ready4", r4, act_left <= 0);
    chk("cycle_count4", cc4, cnt4);
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
    chk("bp_hit", bp_hit, bp_m);
    chk("bp_hit4", bp_hit4, bp_m);
`endif
  end

  task automatic send(input logic [1:0] op, input logic [15:0] n);
    cmd_valid = 1'b1; cmd_op = op; cmd_count = n;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 16'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst pipe_en", pipe_en, 0);
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst count", cycle_count, 0);
    chk("rst done", done, 0);
    reset = 1'b1;
    @(negedge clk);

    // RUN, HALT opcode on the 8th enabled cycle, 4 drain cycles.
    send(C_RUN, 0);
    chk("run pipe_en", pipe_en, 1);
    chk("run count0", cycle_count, 0);
    repeat (7) @(negedge clk);
    instr = HALT_I;
    @(negedge clk);
    instr = 32'd0;
    chk("drain fetch_en", fetch_en, 0);
    chk("drain pipe_en", pipe_en, 1);
    chk("drain count", cycle_count, 8);
    repeat (3) @(negedge clk);
    chk("drain last pipe_en", pipe_en, 1);
    chk("drain last halted", halted, 0);
    @(negedge clk);
    chk("halt pipe_en", pipe_en, 0);
    chk("halt halted", halted, 1);
    chk("halt done", done, 1);
    chk("halt count", cycle_count, 12);
    @(negedge clk);
    chk("halt done once", done, 0);
    chk("halt count hold", cycle_count, 12);

    // RUN ignored while halted, CLEAR leaves HALTED.
    send(C_RUN, 0);
    chk("hlt run ignored", halted, 1);
    chk("hlt run pipe_en", pipe_en, 0);
    chk("hlt cmd_ready", cmd_ready, 1);
    send(C_CLEAR, 0);
    chk("clear halted", halted, 0);
    chk("clear count", cycle_count, 0);

    // STEP 3 then STEP 0.
    send(C_STEP, 3);
    chk("step pipe_en", pipe_en, 1);
    chk("step cmd_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    chk("step3 pipe_en", pipe_en, 1);
    @(negedge clk);
    chk("step end pipe_en", pipe_en, 0);
    chk("step end done", done, 1);
    chk("step count", cycle_count, 3);
    send(C_STEP, 0);
    chk("step0 done", done, 1);
    chk("step0 pipe_en", pipe_en, 0);
    chk("step0 count", cycle_count, 3);
    @(negedge clk);

    // RUN 7 cycles, HALT command, resume, saturate the narrow counter.
    send(C_CLEAR, 0);
    send(C_RUN, 0);
    repeat (6) @(negedge clk);
    send(C_HALT, 0);
    chk("hcmd pipe_en", pipe_en, 0);
    chk("hcmd done", done, 1);
    chk("hcmd count", cycle_count, 7);
    send(C_RUN, 0);
    chk("resume count", cycle_count, 7);
    repeat (12) @(negedge clk);
    chk("resume count19", cycle_count, 19);
    chk("sat count4", cc4, 15);

    // CLEAR while running: the clearing cycle is not counted.
    send(C_CLEAR, 0);
    chk("rclear count", cycle_count, 0);
    chk("rclear count4", cc4, 0);
    @(negedge clk);
    chk("rclear count1", cycle_count, 1);

    // HALT opcode together with a CLEAR command: detection wins.
    cmd_valid = 1'b1; cmd_op = C_CLEAR; instr = HALT_I;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 2'b00; instr = 32'd0;
    chk("coll fetch_en", fetch_en, 0);
    chk("coll pipe_en", pipe_en, 1);
    chk("coll count", cycle_count, 2);
    repeat (4) @(negedge clk);
    chk("coll halted", halted, 1);
    chk("coll count6", cycle_count, 6);
    send(C_CLEAR, 0);

    // HALT opcode on the last STEP cycle: detection beats expiry.
    send(C_STEP, 2);
    @(negedge clk);
    instr = HALT_I;
    @(negedge clk);
    instr = 32'd0;
    chk("stepdet pipe_en", pipe_en, 1);
    chk("stepdet fetch_en", fetch_en, 0);
    chk("stepdet done", done, 0);
    repeat (4) @(negedge clk);
    chk("stepdet halted", halted, 1);
    chk("stepdet count", cycle_count, 6);
    send(C_CLEAR, 0);

    // Asynchronous reset in the middle of DRAIN.
    send(C_RUN, 0);
    instr = HALT_I;
    @(negedge clk);
    instr = 32'd0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst pipe_en", pipe_en, 0);
    chk("arst fetch_en", fetch_en, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst count", cycle_count, 0);
    repeat (2) @(negedge clk);
    chk("arst no done", done, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("arst idle ready", cmd_ready, 1);

`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
    bp_pc = 32'h20; bp_valid = 1'b1; pc_if = 32'd0;
    send(C_RUN, 0);
    repeat (2) @(negedge clk);
    pc_if = 32'h20;
    @(negedge clk);
    pc_if = 32'd0;
    chk("bp pipe_en", pipe_en, 0);
    chk("bp done", done, 1);
    chk("bp hit", bp_hit, 1);
    repeat (3) @(negedge clk);
    chk("bp sticky", bp_hit, 1);
    send(C_STEP, 0);
    chk("bp cleared", bp_hit, 0);
    send(C_RUN, 0);
    pc_if = 32'h20; instr = HALT_I;
    @(negedge clk);
    pc_if = 32'd0; instr = 32'd0;
    chk("bp vs halt fetch_en", fetch_en, 0);
    chk("bp vs halt pipe_en", pipe_en, 1);
    chk("bp vs halt hit", bp_hit, 0);
    repeat (4) @(negedge clk);
    bp_valid = 1'b0;
    send(C_CLEAR, 0);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
